// File: rtl/sr_mem_arbiter.sv
// Arbitrates CPU instruction fetches and a buffered store stream onto one shared memory port.
// Fetches go ahead of buffered stores unless the buffer is full or holds the word being fetched.
module sr_mem_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        im_req,
  input  logic [31:0] im_addr,
  output logic [31:0] im_data,
  output logic        im_drdy,
  input  logic        st_we,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_full,
  output logic        st_ovf,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, STORE} state_e;
  state_e state_q, state_d;

  logic [29:0]   fifo_addr_q [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          fetch_pend_q, fetch_pend_d;
  logic [31:0]   pend_addr_q, pend_addr_d;
  logic [31:0]   act_addr_q, act_addr_d;
  logic [31:0]   im_data_q, im_data_d;
  logic          drdy_q, drdy_d;

  logic          push, pop, hazard, pend_eff;
  logic [31:0]   addr_eff;
  logic [PW-1:0] off;
  logic          unused_st_lsb;

  assign unused_st_lsb = ^st_addr[1:0];

  assign pop  = (state_q == STORE) && mem_ack;
  assign push = st_we && ((count_q != FULL_CNT) || pop);

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q | (st_we & ~push);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= st_addr[31:2];
      fifo_data_q[wr_ptr_q] <= st_data;
    end
  end

  // A registered pending fetch wins over a same-cycle im_req; that new request stays queued.
  assign pend_eff = fetch_pend_q | im_req;
  assign addr_eff = fetch_pend_q ? pend_addr_q : im_addr;

  always_comb begin
    hazard = 1'b0;
    off    = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && ({2'b00, fifo_addr_q[i]} == addr_eff))
        hazard = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pend_d = fetch_pend_q;
    pend_addr_d  = pend_addr_q;
    act_addr_d   = act_addr_q;
    im_data_d    = im_data_q;
    drdy_d       = 1'b0;
    if (im_req) begin
      fetch_pend_d = 1'b1;
      pend_addr_d  = im_addr;
    end
    case (state_q)
      IDLE: begin
        if (count_q == FULL_CNT) begin
          state_d = STORE;
        end else if (pend_eff && hazard) begin
          state_d = STORE;
        end else if (pend_eff) begin
          state_d      = FETCH;
          act_addr_d   = addr_eff;
          fetch_pend_d = fetch_pend_q && im_req;
        end else if (count_q != '0) begin
          state_d = STORE;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          im_data_d = mem_rdata;
          drdy_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      STORE: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      fetch_pend_q <= 1'b0;
      pend_addr_q  <= '0;
      act_addr_q   <= '0;
      im_data_q    <= '0;
      drdy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      fetch_pend_q <= fetch_pend_d;
      pend_addr_q  <= pend_addr_d;
      act_addr_q   <= act_addr_d;
      im_data_q    <= im_data_d;
      drdy_q       <= drdy_d;
    end
  end

  // Port outputs decode from registered state so reset clears them without a clock.
  assign mem_req   = (state_q != IDLE);
  assign mem_we    = (state_q == STORE);
  assign mem_addr  = (state_q == FETCH) ? act_addr_q :
                     (state_q == STORE) ? {2'b00, fifo_addr_q[rd_ptr_q]} : 32'h0;
  assign mem_wdata = (state_q == STORE) ? fifo_data_q[rd_ptr_q] : 32'h0;
  assign st_full   = (count_q == FULL_CNT);
  assign st_ovf    = ovf_q;
  assign im_data   = im_data_q;
  assign im_drdy   = drdy_q;
endmodule

// File: tb/tb_sr_mem_arbiter.sv
// Bench for sr_mem_arbiter: memory responder, scoreboard monitor, directed scenarios then random traffic.
module tb_sr_mem_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        im_req = 1'b0, st_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] im_addr = '0, st_addr = '0, st_data = '0, mem_rdata = '0;
  logic [31:0] im_data, mem_addr, mem_wdata;
  logic        im_drdy, st_full, st_ovf, mem_req, mem_we;

  sr_mem_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr), .im_data(im_data),
    .im_drdy(im_drdy), .st_we(st_we), .st_addr(st_addr), .st_data(st_data),
    .st_full(st_full), .st_ovf(st_ovf), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; int cyc; } txn_t;
  int checks = 0, errors = 0;
  txn_t        log_q[$];
  logic [31:0] fa_q[$], fd_q[$];
  logic [63:0] st_q[$];
  int fetch_issued = 0, drdy_cnt = 0, st_issued = 0, st_done = 0;
  int lat_min = 1, lat_max = 1, stray_req = 0;
  bit stall = 1'b0;

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fval(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // Memory responder: latency in [lat_min,lat_max] cycles counted from the first mem_req cycle.
  logic [31:0] mem [logic [31:0]];
  int wcnt = 0, lat = 1, stray_seen = 0;
  always @(posedge clk) begin
    #2;
    if (rst) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (stray_req != stray_seen) begin
      stray_seen = stray_req;
      mem_ack = 1'b1;
    end else if (mem_req) begin
      if (wcnt == 0) lat = $urandom_range(lat_max, lat_min);
      wcnt++;
      if (!stall && wcnt >= lat) begin
        mem_ack = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else if (mem.exists(mem_addr)) mem_rdata = mem[mem_addr];
        else if (mem_addr == 32'h10) mem_rdata = 32'h00500093;
        else mem_rdata = fval(mem_addr);
      end
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pops on each completed transaction.
  logic prev_req = 0, prev_ack = 0, prev_we = 0;
  logic [31:0] prev_addr = 0, prev_wdata = 0;
  int cyc = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 0; prev_ack = 0; cyc = 0;
    end else begin
      if (prev_ack) chk("idle_gap_after_ack", {95'h0, mem_req}, 96'h0);
      else if (prev_req && mem_req)
        chk("mem_stable", {31'h0, mem_we, mem_addr, mem_wdata}, {31'h0, prev_we, prev_addr, prev_wdata});
      if (mem_req) cyc++;
      if (mem_req && mem_ack) begin
        log_q.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata, cyc});
        cyc = 0;
        if (mem_we) begin
          st_done++;
          checks++;
          if (st_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_store: addr %0h data %0h", mem_addr, mem_wdata);
          end else chk("store_txn", {32'h0, mem_addr, mem_wdata}, {32'h0, st_q.pop_front()});
        end else begin
          checks++;
          if (fa_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_fetch: addr %0h", mem_addr);
          end else chk("fetch_addr", {64'h0, mem_addr}, {64'h0, fa_q.pop_front()});
        end
      end
      if (im_drdy) begin
        drdy_cnt++;
        checks++;
        if (fd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_drdy: data %0h", im_data);
        end else chk("fetch_data", {64'h0, im_data}, {64'h0, fd_q.pop_front()});
      end
      prev_req = mem_req; prev_ack = mem_req && mem_ack;
      prev_we = mem_we; prev_addr = mem_addr; prev_wdata = mem_wdata;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(logic [31:0] a, logic [31:0] d, bit expect_done);
    im_req = 1'b1; im_addr = a;
    if (expect_done) begin
      fa_q.push_back(a); fd_q.push_back(d); fetch_issued++;
    end
    tick(1);
    im_req = 1'b0;
  endtask

  task automatic do_store(logic [31:0] sa, logic [31:0] sd, bit accepted);
    st_we = 1'b1; st_addr = sa; st_data = sd;
    if (accepted) begin
      st_q.push_back({sa >> 2, sd}); st_issued++;
    end
    tick(1);
    st_we = 1'b0;
  endtask

  task automatic wait_log(int n, string name);
    int t = 0;
    while (log_q.size() < n && t < 300) begin tick(1); t++; end
    if (log_q.size() < n) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d transactions required %0d", name, log_q.size(), n);
    end
  endtask

  task automatic chk_txn(string name, int idx, logic we, logic [31:0] addr, logic [31:0] data);
    if (idx < log_q.size())
      chk(name, {31'h0, log_q[idx].we, log_q[idx].addr, log_q[idx].data}, {31'h0, we, addr, data});
  endtask

  task automatic wait_quiet(string name);
    int t = 0;
    while ((drdy_cnt != fetch_issued || st_done != st_issued || mem_req) && t < 400) begin
      tick(1); t++;
    end
    chk({name, "_fetches"}, 96'(drdy_cnt), 96'(fetch_issued));
    chk({name, "_stores"}, 96'(st_done), 96'(st_issued));
  endtask

  int base;
  logic [31:0] a, sa;

  initial begin
    #2;
    chk("reset_outputs", {im_data, mem_addr, mem_wdata},
        {64'h0, 32'h0} | {im_drdy, st_full, st_ovf, mem_req, mem_we, 91'h0});
    tick(2);
    rst = 1'b0;
    tick(1);

    // Basic fetch with 2-cycle memory latency.
    lat_min = 2; lat_max = 2; base = log_q.size();
    do_fetch(32'h10, 32'h00500093, 1'b1);
    wait_log(base + 1, "fetch");
    chk_txn("fetch_txn", base, 1'b0, 32'h10, 32'h00500093);
    if (base < log_q.size()) chk("fetch_req_cycles", 96'(log_q[base].cyc), 96'd2);
    tick(4);
    chk("fetch_drdy_once", 96'(drdy_cnt), 96'd1);
    chk("im_data_hold", {64'h0, im_data}, {64'h0, 32'h00500093});

    // Minimum latency: request n, FETCH+ack n+1, drdy n+2.
    lat_min = 1; lat_max = 1;
    im_req = 1'b1; im_addr = 32'h11;
    fa_q.push_back(32'h11); fd_q.push_back(fval(32'h11)); fetch_issued++;
    @(negedge clk); chk("lat_cycle0_req", {95'h0, mem_req}, 96'h0);
    tick(1); im_req = 1'b0;
    @(negedge clk); chk("lat_cycle1_req_ack", {94'h0, mem_req, mem_ack}, 96'h3);
    @(negedge clk); chk("lat_cycle2_drdy", {95'h0, im_drdy}, 96'h1);
    tick(2);

    // Single store: byte 0x40 lands at word 0x10.
    lat_max = 2; base = log_q.size();
    do_store(32'h40, 32'hAA, 1'b1);
    wait_log(base + 1, "store");
    chk_txn("store_word_addr", base, 1'b1, 32'h10, 32'hAA);
    tick(4);
    chk("store_drained_idle", {94'h0, mem_req, st_full}, 96'h0);

    // Priority: pending fetch without a match goes before buffered stores.
    stall = 1'b1; base = log_q.size();
    do_fetch(32'h30, fval(32'h30), 1'b1);
    do_store(32'h80, 32'h1111, 1'b1);
    do_store(32'h84, 32'h2222, 1'b1);
    do_fetch(32'h31, fval(32'h31), 1'b1);
    stall = 1'b0;
    wait_log(base + 4, "prio");
    chk_txn("prio_0", base,     1'b0, 32'h30, fval(32'h30));
    chk_txn("prio_1", base + 1, 1'b0, 32'h31, fval(32'h31));
    chk_txn("prio_2", base + 2, 1'b1, 32'h20, 32'h1111);
    chk_txn("prio_3", base + 3, 1'b1, 32'h21, 32'h2222);
    wait_quiet("prio");

    // Hazard: fetch of a word held in the buffer waits for that store.
    stall = 1'b1; base = log_q.size();
    do_fetch(32'h32, fval(32'h32), 1'b1);
    do_store(32'h40, 32'h55551234, 1'b1);
    do_fetch(32'h10, 32'h55551234, 1'b1);
    stall = 1'b0;
    wait_log(base + 3, "hazard");
    chk_txn("hazard_0", base,     1'b0, 32'h32, fval(32'h32));
    chk_txn("hazard_1", base + 1, 1'b1, 32'h10, 32'h55551234);
    chk_txn("hazard_2", base + 2, 1'b0, 32'h10, 32'h55551234);
    wait_quiet("hazard");

    // Full/overflow: 5 stores into a stalled 4-deep buffer; fetch word matches the 4th store.
    stall = 1'b1; base = log_q.size();
    do_fetch(32'h33, fval(32'h33), 1'b1);
    for (int i = 0; i < 5; i++) begin
      do_store(32'h80 + 32'(4 * i), 32'hC000 + 32'(i), i < 4);
      if (i == 2) chk("not_full_at_3", {95'h0, st_full}, 96'h0);
      if (i == 3) chk("full_at_4", {94'h0, st_full, st_ovf}, 96'h2);
      if (i == 4) chk("ovf_at_5", {94'h0, st_full, st_ovf}, 96'h3);
    end
    do_fetch(32'h23, 32'hC003, 1'b1);
    stall = 1'b0;
    wait_log(base + 6, "full");
    chk_txn("full_0", base, 1'b0, 32'h33, fval(32'h33));
    for (int i = 0; i < 4; i++)
      chk_txn("full_drain", base + 1 + i, 1'b1, 32'h20 + 32'(i), 32'hC000 + 32'(i));
    chk_txn("full_5", base + 5, 1'b0, 32'h23, 32'hC003);
    wait_quiet("full");
    chk("ovf_sticky", {94'h0, st_full, st_ovf}, 96'h1);

    // Reset in the middle of a stalled fetch with a store buffered.
    stall = 1'b1;
    do_fetch(32'h34, 32'h0, 1'b0);
    do_store(32'h200, 32'hDEAD, 1'b0);
    tick(1);
    #2 rst = 1'b1;
    #1 chk("rst_mid_outputs", {im_data, mem_addr, mem_wdata},
           {96'h0} | {im_drdy, st_full, st_ovf, mem_req, mem_we, 91'h0});
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; stray_req++;
    base = log_q.size();
    tick(6);
    chk("rst_no_txn", 96'(log_q.size()), 96'(base));
    chk("rst_no_drdy", 96'(drdy_cnt), 96'(fetch_issued));
    chk("rst_idle", {94'h0, mem_req, st_ovf}, 96'h0);

    // Random traffic: fetches above word 0x100, stores below it.
    lat_min = 1; lat_max = 3;
    for (int c = 0; c < 2000; c++) begin
      im_req = 1'b0; st_we = 1'b0;
      if (drdy_cnt == fetch_issued && $urandom_range(3) == 0) begin
        a = 32'h100 + 32'($urandom_range(255));
        im_req = 1'b1; im_addr = a;
        fa_q.push_back(a); fd_q.push_back(fval(a)); fetch_issued++;
      end
      if (st_issued - st_done < DEPTH && $urandom_range(2) == 0) begin
        sa = 32'($urandom_range(255)) << 2;
        st_we = 1'b1; st_addr = sa; st_data = $urandom;
        st_q.push_back({sa >> 2, st_data}); st_issued++;
      end
      tick(1);
    end
    im_req = 1'b0; st_we = 1'b0;
    wait_quiet("random_drain");
    chk("random_no_ovf", {95'h0, st_ovf}, 96'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
